// File: rtl/game_seq.sv
// game_seq: frame-rate game-flow sequencer for the PacMan datapath.
// Owns lives, the ready/death countdown, the frightened counter and user pause,
// and turns collision / power-pellet / pellet-count status into mover controls.
module game_seq #(
  parameter int START_LIVES   = 3,
  parameter int READY_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 90,
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120,
  parameter logic [7:0] KEY_START = 8'h2C,
  parameter logic [7:0] KEY_PAUSE = 8'h13
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       ghost_hit,
  input  logic       power_eaten,
  input  logic [7:0] pellets_left,
  output logic       pause,
  output logic       lifeDown,
  output logic       new_game,
  output logic [1:0] lives,
  output logic       fright,
  output logic       fright_blink,
  output logic       ghost_eaten,
  output logic [2:0] state,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    PLAY    = 3'd2,
    PAUSED  = 3'd3,
    DYING   = 3'd4,
    RESPAWN = 3'd5,
    OVER    = 3'd6,
    WIN     = 3'd7
  } state_t;

  localparam logic [9:0] READY_LOAD  = 10'(READY_FRAMES - 1);
  localparam logic [9:0] DEATH_LOAD  = 10'(DEATH_FRAMES - 1);
  localparam logic [8:0] FRIGHT_LOAD = 9'(FRIGHT_FRAMES);
  localparam logic [8:0] BLINK_LIMIT = 9'(BLINK_FRAMES);
  localparam logic [1:0] LIVES_LOAD  = 2'(START_LIVES);

  state_t     cur_state, nxt_state;
  logic [9:0] timer, timer_nxt;
  logic [8:0] fright_cnt, fright_cnt_nxt;
  logic [1:0] lives_nxt;
  logic [7:0] key_prev;
  logic       start_press, pause_press, fright_active;
  logic       new_game_nxt, life_down_nxt, ghost_eaten_nxt;
  logic       fright_blink_nxt;

  // A press is the first frame a key code appears, so holding a key acts once.
  assign start_press   = (keycode == KEY_START) && (key_prev != KEY_START);
  assign pause_press   = (keycode == KEY_PAUSE) && (key_prev != KEY_PAUSE);
  assign fright_active = (fright_cnt != 9'd0);
  assign state         = cur_state;

  // Next-state, counter and pulse decisions for the current frame.
  always_comb begin
    nxt_state       = cur_state;
    timer_nxt       = timer;
    fright_cnt_nxt  = fright_cnt;
    lives_nxt       = lives;
    new_game_nxt    = 1'b0;
    life_down_nxt   = 1'b0;
    ghost_eaten_nxt = 1'b0;

    case (cur_state)
      IDLE, OVER, WIN: begin
        fright_cnt_nxt = 9'd0;
        if (start_press) begin
          nxt_state     = READY;
          timer_nxt     = READY_LOAD;
          lives_nxt     = LIVES_LOAD;
          new_game_nxt  = 1'b1;
          life_down_nxt = 1'b1;
        end
      end

      READY: begin
        if (timer == 10'd0) nxt_state = PLAY;
        else                timer_nxt = timer - 10'd1;
      end

      PLAY: begin
        if (pellets_left == 8'd0) begin
          nxt_state      = WIN;
          fright_cnt_nxt = 9'd0;
        end else if (ghost_hit && !fright_active) begin
          nxt_state      = DYING;
          timer_nxt      = DEATH_LOAD;
          fright_cnt_nxt = 9'd0;
        end else begin
          if (power_eaten)        fright_cnt_nxt = FRIGHT_LOAD;
          else if (fright_active) fright_cnt_nxt = fright_cnt - 9'd1;
          if (ghost_hit)          ghost_eaten_nxt = 1'b1;
          else if (pause_press)   nxt_state = PAUSED;
        end
      end

      PAUSED: begin
        if (pause_press) nxt_state = PLAY;
      end

      DYING: begin
        if (timer != 10'd0) begin
          timer_nxt = timer - 10'd1;
        end else if (lives == 2'd1) begin
          lives_nxt = 2'd0;
          nxt_state = OVER;
        end else begin
          nxt_state     = RESPAWN;
          life_down_nxt = 1'b1;
          if (lives != 2'd0) lives_nxt = lives - 2'd1;
        end
      end

      RESPAWN: begin
        nxt_state = READY;
        timer_nxt = READY_LOAD;
      end

      default: nxt_state = IDLE;
    endcase

    fright_blink_nxt = (fright_cnt_nxt != 9'd0) && (fright_cnt_nxt <= BLINK_LIMIT);
  end

  // Frame register: state, counters, key history and every registered output.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      cur_state    <= IDLE;
      timer        <= 10'd0;
      fright_cnt   <= 9'd0;
      lives        <= LIVES_LOAD;
      key_prev     <= 8'h00;
      pause        <= 1'b1;
      lifeDown     <= 1'b0;
      new_game     <= 1'b0;
      ghost_eaten  <= 1'b0;
      fright       <= 1'b0;
      fright_blink <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      timer        <= timer_nxt;
      fright_cnt   <= fright_cnt_nxt;
      lives        <= lives_nxt;
      key_prev     <= keycode;
      pause        <= (nxt_state != PLAY);
      lifeDown     <= life_down_nxt;
      new_game     <= new_game_nxt;
      ghost_eaten  <= ghost_eaten_nxt;
      fright       <= (fright_cnt_nxt != 9'd0);
      fright_blink <= fright_blink_nxt;
      game_over    <= (nxt_state == OVER);
      win          <= (nxt_state == WIN);
    end
  end

endmodule

// File: tb/tb_game_seq.sv
// tb_game_seq: directed scenario bench for the game_seq frame sequencer.
module tb_game_seq;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       ghost_hit;
  logic       power_eaten;
  logic [7:0] pellets_left;
  logic       pause, lifeDown, new_game, fright, fright_blink, ghost_eaten;
  logic       game_over, win;
  logic [1:0] lives;
  logic [2:0] state;

  int vectors;
  int miscompares;

  game_seq dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .ghost_hit    (ghost_hit),
    .power_eaten  (power_eaten),
    .pellets_left (pellets_left),
    .pause        (pause),
    .lifeDown     (lifeDown),
    .new_game     (new_game),
    .lives        (lives),
    .fright       (fright),
    .fright_blink (fright_blink),
    .ghost_eaten  (ghost_eaten),
    .state        (state),
    .game_over    (game_over),
    .win          (win)
  );

  // Free-running frame clock.
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Absolute time limit so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // One frame: let the active edge happen, then sample on the falling edge.
  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  // Counts frames spent in READY (current frame included) until it leaves.
  task automatic count_ready(input int already, output int frames);
    frames = already;
    while (state == 3'd1 && frames < 400) begin
      tick();
      if (state == 3'd1) frames++;
    end
  endtask

  // Counts frames spent in DYING (current frame included) until it leaves.
  task automatic count_dying(output int frames);
    frames = 1;
    while (state == 3'd4 && frames < 400) begin
      tick();
      if (state == 3'd4) frames++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h00; ghost_hit = 1'b0; power_eaten = 1'b0;
    pellets_left = 8'd100;
    tick(); tick();
    Reset = 1'b1;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (pause !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_pause: got %0b expected 1", pause); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("[TB] FAIL reset_lives: got %0d expected 3", lives); end
    vectors++; if ({fright, fright_blink} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_fright: got %b expected 00", {fright, fright_blink}); end
    vectors++; if ({new_game, lifeDown, ghost_eaten, game_over, win} !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_pulses: got %b expected 00000", {new_game, lifeDown, ghost_eaten, game_over, win}); end
    tick();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL idle_hold: got %0d expected 0", state); end
  endtask

  task automatic test_start_and_ready();
    int ng_cnt, ld_cnt, rdy;
    ng_cnt = 0; ld_cnt = 0;
    keycode = 8'h2C;
    tick();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
    vectors++; if ({new_game, lifeDown} !== 2'b11) begin miscompares++; $display("[TB] FAIL start_pulses: got %b expected 11", {new_game, lifeDown}); end
    if (new_game) ng_cnt++;
    if (lifeDown) ld_cnt++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (new_game) ng_cnt++;
      if (lifeDown) ld_cnt++;
    end
    keycode = 8'h00;
    vectors++; if (ng_cnt !== 1) begin miscompares++; $display("[TB] FAIL held_start_new_game: got %0d pulses expected 1", ng_cnt); end
    vectors++; if (ld_cnt !== 1) begin miscompares++; $display("[TB] FAIL held_start_lifeDown: got %0d pulses expected 1", ld_cnt); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL held_start_state: got %0d expected 1", state); end
    count_ready(10, rdy);
    vectors++; if (rdy !== 120) begin miscompares++; $display("[TB] FAIL ready_length: got %0d frames expected 120", rdy); end
    vectors++; if ({state, pause} !== {3'd2, 1'b0}) begin miscompares++; $display("[TB] FAIL play_entry: got state %0d pause %0b expected 2 0", state, pause); end
  endtask

  task automatic test_fright();
    int f, blink_at;
    power_eaten = 1'b1;
    tick();
    power_eaten = 1'b0;
    vectors++; if ({fright, fright_blink} !== 2'b10) begin miscompares++; $display("[TB] FAIL fright_load: got %b expected 10", {fright, fright_blink}); end
    f = 1; blink_at = 0;
    while (fright && f < 500) begin
      if (f == 10) begin
        ghost_hit = 1'b1;
        tick();
        ghost_hit = 1'b0;
        vectors++; if ({ghost_eaten, state, lives} !== {1'b1, 3'd2, 2'd3}) begin miscompares++; $display("[TB] FAIL ghost_eaten_hit: got eaten %0b state %0d lives %0d expected 1 2 3", ghost_eaten, state, lives); end
        tick();
        vectors++; if (ghost_eaten !== 1'b0) begin miscompares++; $display("[TB] FAIL ghost_eaten_width: got %0b expected 0", ghost_eaten); end
        f += 2;
      end else begin
        tick();
        if (fright) f++;
      end
      if (fright_blink && blink_at == 0) blink_at = f;
    end
    vectors++; if (f !== 360) begin miscompares++; $display("[TB] FAIL fright_length: got %0d frames expected 360", f); end
    vectors++; if (blink_at !== 241) begin miscompares++; $display("[TB] FAIL blink_start: got frame %0d expected 241", blink_at); end
    vectors++; if ({state, fright_blink} !== {3'd2, 1'b0}) begin miscompares++; $display("[TB] FAIL fright_end: got state %0d blink %0b expected 2 0", state, fright_blink); end
  endtask

  task automatic test_pause_fright();
    int f, bad;
    power_eaten = 1'b1;
    tick();
    power_eaten = 1'b0;
    for (int i = 0; i < 160; i++) tick();
    keycode = 8'h13;
    tick();
    vectors++; if ({state, pause} !== {3'd3, 1'b1}) begin miscompares++; $display("[TB] FAIL pause_enter: got state %0d pause %0b expected 3 1", state, pause); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      ghost_hit   = (i == 20);
      power_eaten = (i == 20);
      tick();
      if (state != 3'd3 || !pause || !fright || ghost_eaten) bad++;
    end
    ghost_hit = 1'b0; power_eaten = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL paused_hold: got %0d bad frames expected 0", bad); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("[TB] FAIL paused_lives: got %0d expected 3", lives); end
    keycode = 8'h00;
    tick();
    keycode = 8'h13;
    tick();
    keycode = 8'h00;
    vectors++; if ({state, pause} !== {3'd2, 1'b0}) begin miscompares++; $display("[TB] FAIL pause_resume: got state %0d pause %0b expected 2 0", state, pause); end
    f = 1;
    while (fright && f < 500) begin
      tick();
      if (fright) f++;
    end
    vectors++; if (f !== 199) begin miscompares++; $display("[TB] FAIL fright_after_pause: got %0d frames expected 199", f); end
  endtask

  task automatic test_death();
    int d, rdy;
    for (int k = 3; k >= 1; k--) begin
      ghost_hit = 1'b1;
      tick();
      ghost_hit = 1'b0;
      vectors++; if ({state, pause} !== {3'd4, 1'b1}) begin miscompares++; $display("[TB] FAIL death_enter: got state %0d pause %0b expected 4 1", state, pause); end
      count_dying(d);
      vectors++; if (d !== 90) begin miscompares++; $display("[TB] FAIL death_length: got %0d frames expected 90", d); end
      if (k > 1) begin
        vectors++; if ({state, lifeDown, lives} !== {3'd5, 1'b1, 2'(k - 1)}) begin miscompares++; $display("[TB] FAIL respawn: got state %0d lifeDown %0b lives %0d expected 5 1 %0d", state, lifeDown, lives, k - 1); end
        tick();
        vectors++; if ({state, lifeDown} !== {3'd1, 1'b0}) begin miscompares++; $display("[TB] FAIL respawn_ready: got state %0d lifeDown %0b expected 1 0", state, lifeDown); end
        count_ready(1, rdy);
        vectors++; if (rdy !== 120 || state !== 3'd2) begin miscompares++; $display("[TB] FAIL respawn_play: got %0d frames state %0d expected 120 2", rdy, state); end
      end else begin
        vectors++; if ({state, game_over, lives, lifeDown} !== {3'd6, 1'b1, 2'd0, 1'b0}) begin miscompares++; $display("[TB] FAIL game_over: got state %0d over %0b lives %0d lifeDown %0b expected 6 1 0 0", state, game_over, lives, lifeDown); end
      end
    end
    ghost_hit = 1'b1;
    tick();
    ghost_hit = 1'b0;
    vectors++; if ({state, lives} !== {3'd6, 2'd0}) begin miscompares++; $display("[TB] FAIL over_hold: got state %0d lives %0d expected 6 0", state, lives); end
  endtask

  task automatic test_new_game_from_over();
    int rdy;
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    vectors++; if ({state, new_game, lifeDown, lives, game_over} !== {3'd1, 1'b1, 1'b1, 2'd3, 1'b0}) begin miscompares++; $display("[TB] FAIL restart_over: got state %0d ng %0b ld %0b lives %0d over %0b expected 1 1 1 3 0", state, new_game, lifeDown, lives, game_over); end
    count_ready(1, rdy);
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL restart_play: got %0d expected 2", state); end
  endtask

  task automatic test_win_collision();
    pellets_left = 8'd0;
    ghost_hit = 1'b1;
    tick();
    ghost_hit = 1'b0;
    pellets_left = 8'd50;
    vectors++; if ({state, win, lives, lifeDown, pause} !== {3'd7, 1'b1, 2'd3, 1'b0, 1'b1}) begin miscompares++; $display("[TB] FAIL win_collision: got state %0d win %0b lives %0d ld %0b pause %0b expected 7 1 3 0 1", state, win, lives, lifeDown, pause); end
  endtask

  task automatic test_reset_mid_dying();
    int d, rdy;
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    vectors++; if ({state, new_game, win} !== {3'd1, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL restart_win: got state %0d ng %0b win %0b expected 1 1 0", state, new_game, win); end
    count_ready(1, rdy);
    ghost_hit = 1'b1;
    power_eaten = 1'b1;
    tick();
    ghost_hit = 1'b0;
    power_eaten = 1'b0;
    vectors++; if ({state, fright} !== {3'd4, 1'b0}) begin miscompares++; $display("[TB] FAIL death_beats_power: got state %0d fright %0b expected 4 0", state, fright); end
    count_dying(d);
    tick();
    count_ready(1, rdy);
    vectors++; if ({state, lives} !== {3'd2, 2'd2}) begin miscompares++; $display("[TB] FAIL second_play: got state %0d lives %0d expected 2 2", state, lives); end
    ghost_hit = 1'b1;
    tick();
    ghost_hit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    vectors++; if ({state, lives, pause, fright} !== {3'd0, 2'd3, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL reset_mid_dying: got state %0d lives %0d pause %0b fright %0b expected 0 3 1 0", state, lives, pause, fright); end
    tick();
    vectors++; if ({state, lifeDown} !== {3'd0, 1'b0}) begin miscompares++; $display("[TB] FAIL idle_after_reset: got state %0d ld %0b expected 0 0", state, lifeDown); end
  endtask

  // Scenario sequence.
  initial begin
    vectors = 0;
    miscompares = 0;
    Reset = 1'b0; keycode = 8'h00; ghost_hit = 1'b0; power_eaten = 1'b0;
    pellets_left = 8'd100;
    @(negedge frame_clk);
    test_reset();
    test_start_and_ready();
    test_fright();
    test_pause_fright();
    test_death();
    test_new_game_from_over();
    test_win_collision();
    test_reset_mid_dying();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
